// File: rtl/scan_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : scan_seq_pkg                                                    |
// | Purpose  : Shared types and elaboration-time helpers for the scan-window   |
// |            sequencer: state encoding, per-level limit tables, legal-level  |
// |            walk tables and lane-mask evaluation.                           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

`ifndef PYRAMID_LEVELS
`define PYRAMID_LEVELS 2
`endif
`ifndef PYRAMID_WIDTHS
`define PYRAMID_WIDTHS {32'd6, 32'd8}
`endif
`ifndef PYRAMID_HEIGHTS
`define PYRAMID_HEIGHTS {32'd5, 32'd6}
`endif
`ifndef WINDOW_SIZE
`define WINDOW_SIZE 4
`endif

package scan_seq_pkg;

  // Level index travels on a 4-bit bus, so at most 16 levels exist.
  localparam int MAX_LEVELS = 16;
  localparam int MAX_LANES  = 32;

  typedef logic [MAX_LEVELS-1:0][31:0] dim_table_t;
  typedef logic [MAX_LEVELS-1:0]       level_mask_t;
  typedef logic [MAX_LEVELS-1:0][3:0]  level_table_t;
  typedef logic [MAX_LANES-1:0]        lane_mask_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SCAN   = 2'd2
  } seq_state_t;

  // Largest legal column origin per level (only meaningful for legal levels).
  function automatic dim_table_t level_max_col(input dim_table_t w, input logic [31:0] ws);
    dim_table_t r;
    for (int i = 0; i < MAX_LEVELS; i++) r[i] = w[i] - ws - 32'd1;
    return r;
  endfunction

  // Largest legal row origin per level (only meaningful for legal levels).
  function automatic dim_table_t level_max_row(input dim_table_t h, input logic [31:0] ws);
    dim_table_t r;
    for (int i = 0; i < MAX_LEVELS; i++) r[i] = h[i] - ws - 32'd1;
    return r;
  endfunction

  // A level is scanned only when the window fits strictly inside it.
  function automatic level_mask_t level_legal(input dim_table_t w, input dim_table_t h,
                                              input logic [31:0] ws, input int levels);
    level_mask_t m;
    m = '0;
    for (int i = 0; i < MAX_LEVELS; i++)
      if (i < levels && w[i] > ws && h[i] > ws) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [3:0] first_legal_level(input level_mask_t m);
    logic [3:0] r;
    r = 4'd0;
    for (int i = MAX_LEVELS - 1; i >= 0; i--) if (m[i]) r = 4'(i);
    return r;
  endfunction

  function automatic logic [3:0] last_legal_level(input level_mask_t m);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < MAX_LEVELS; i++) if (m[i]) r = 4'(i);
    return r;
  endfunction

  // Entry i holds the next legal level above i (or i itself if none).
  function automatic level_table_t next_legal_level(input level_mask_t m);
    level_table_t t;
    for (int i = 0; i < MAX_LEVELS; i++) begin
      t[i] = 4'(i);
      for (int j = MAX_LEVELS - 1; j > i; j--) if (m[j]) t[i] = 4'(j);
    end
    return t;
  endfunction

  // Largest row/column origin over all legal levels, for range checking.
  function automatic logic [31:0] max_legal_coord(input dim_table_t mc, input dim_table_t mr,
                                                  input level_mask_t m);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < MAX_LEVELS; i++) begin
      if (m[i] && mc[i] > r) r = mc[i];
      if (m[i] && mr[i] > r) r = mr[i];
    end
    return r;
  endfunction

  // Bit i set when lane i's column origin is still inside the level.
  function automatic lane_mask_t lane_mask_calc(input logic [31:0] col, input logic [31:0] max_col,
                                                input logic [31:0] stride, input int lanes);
    lane_mask_t m;
    m = '0;
    for (int i = 0; i < MAX_LANES; i++)
      if (i < lanes && (col + 32'(i) * stride) <= max_col) m[i] = 1'b1;
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/scan_axis_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : scan_axis_counter                                               |
// | Purpose  : Stride stepping counter for one scan axis. Steps by STEP on     |
// |            advance and returns to zero when the step would pass limit.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

module scan_axis_counter
  import scan_seq_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        advance,
  input  logic [31:0] limit,
  output logic [31:0] value,
  output logic        wrap
);

  logic [31:0] stepped;

  // wrap is a look-ahead: high whenever the next advance returns to zero,
  // which also marks the current value as the last legal position.
  assign stepped = value + 32'(STEP);
  assign wrap    = stepped > limit;

  // Position register: cleared outside the scan, stepped on each advance.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      value <= 32'd0;
    end else if (advance) begin
      value <= wrap ? 32'd0 : stepped;
    end
  end

endmodule

`default_nettype wire

// File: rtl/scan_window_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : scan_window_sequencer                                           |
// | Purpose  : Walks every legal pyramid level in row-major order after a      |
// |            settle delay, emitting LANES window positions per beat over a   |
// |            valid/ready handshake, with abort and done signalling.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

module scan_window_sequencer
  import scan_seq_pkg::*;
#(
  parameter int                        LEVELS        = `PYRAMID_LEVELS,
  parameter logic [LEVELS-1:0][31:0]   LEVEL_WIDTHS  = `PYRAMID_WIDTHS,
  parameter logic [LEVELS-1:0][31:0]   LEVEL_HEIGHTS = `PYRAMID_HEIGHTS,
  parameter int                        WINDOW_SIZE   = `WINDOW_SIZE,
  parameter int                        STRIDE        = 1,
  parameter int                        LANES         = 1,
  parameter int                        SETTLE_CYCLES = 10,
  parameter int                        COORD_W       = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [3:0]         win_level,
  output logic [COORD_W-1:0] win_row,
  output logic [COORD_W-1:0] win_col,
  output logic [LANES-1:0]   win_lane_mask,
  output logic               win_level_last,
  output logic               win_frame_last,
  output logic               busy,
  output logic               done
);

  function automatic dim_table_t widen(input logic [LEVELS-1:0][31:0] t);
    dim_table_t r;
    r = '0;
    for (int i = 0; i < LEVELS; i++) r[i] = t[i];
    return r;
  endfunction

  // All level geometry is folded into constant tables at elaboration.
  localparam dim_table_t   W_TAB     = widen(LEVEL_WIDTHS);
  localparam dim_table_t   H_TAB     = widen(LEVEL_HEIGHTS);
  localparam logic [31:0]  WS        = 32'(WINDOW_SIZE);
  localparam level_mask_t  LEGAL     = level_legal(W_TAB, H_TAB, WS, LEVELS);
  localparam dim_table_t   MAXC_TAB  = level_max_col(W_TAB, WS);
  localparam dim_table_t   MAXR_TAB  = level_max_row(H_TAB, WS);
  localparam logic [3:0]   FIRST_LVL = first_legal_level(LEGAL);
  localparam logic [3:0]   LAST_LVL  = last_legal_level(LEGAL);
  localparam level_table_t NEXT_LVL  = next_legal_level(LEGAL);
  localparam logic         ANY_LEGAL = |LEGAL;
  localparam logic [31:0]  MAX_COORD = max_legal_coord(MAXC_TAB, MAXR_TAB, LEGAL);

  if (LEVELS < 1 || LEVELS > MAX_LEVELS) begin : g_chk_levels
    $error("LEVELS must be 1..16");
  end
  if (STRIDE < 1) begin : g_chk_stride
    $error("STRIDE must be >= 1");
  end
  if (LANES < 1 || LANES > MAX_LANES) begin : g_chk_lanes
    $error("LANES must be 1..32");
  end
  if (SETTLE_CYCLES < 1) begin : g_chk_settle
    $error("SETTLE_CYCLES must be >= 1");
  end
  if (COORD_W < 1 || COORD_W > 32) begin : g_chk_coord_w
    $error("COORD_W must be 1..32");
  end
  if (COORD_W < 32 && (MAX_COORD >> COORD_W) != 32'd0) begin : g_chk_coord_range
    $error("window coordinates do not fit in COORD_W bits");
  end

  seq_state_t  state, state_nxt;
  logic [31:0] settle_cnt, settle_nxt;
  logic        done_nxt;
  logic        scan;
  logic [3:0]  level;
  logic [31:0] col, row;
  logic        col_wrap, row_wrap;
  logic [31:0] cur_max_col, cur_max_row;
  logic        accept, advance, clear;
  logic        level_last, frame_last;

  assign cur_max_col = MAXC_TAB[level];
  assign cur_max_row = MAXR_TAB[level];

  // Abort outranks a simultaneous acceptance: the beat is gone downstream
  // but the position does not move, and the state machine leaves SCAN.
  assign accept  = win_valid && win_ready;
  assign advance = accept && !abort;
  assign clear   = (state != ST_SCAN);

  // This beat is the level's last when both axes sit on their last position.
  assign level_last = row_wrap && col_wrap;
  assign frame_last = level_last && (level == LAST_LVL);

  // State register, settle counter and the registered done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      settle_cnt <= 32'd0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      done       <= done_nxt;
    end
  end

  // Next-state logic: start from IDLE, settle, scan, abort back to IDLE.
  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    done_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt  = ST_SETTLE;
          settle_nxt = 32'd1;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_nxt  = ST_IDLE;
          settle_nxt = 32'd0;
        end else if (settle_cnt == 32'(SETTLE_CYCLES)) begin
          settle_nxt = 32'd0;
          if (ANY_LEGAL) begin
            state_nxt = ST_SCAN;
          end else begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end else begin
          settle_nxt = settle_cnt + 32'd1;
        end
      end
      ST_SCAN: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (accept && frame_last) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt  = ST_IDLE;
        settle_nxt = 32'd0;
      end
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    scan      = (state == ST_SCAN);
    win_valid = scan;
    busy      = (state != ST_IDLE);
  end

  // Level register: loads the first legal level on start, then walks the
  // legal-level table each time the row axis wraps.
  always_ff @(posedge clock) begin
    if (reset) begin
      level <= 4'd0;
    end else if (state == ST_IDLE && start) begin
      level <= FIRST_LVL;
    end else if (advance && col_wrap && row_wrap) begin
      level <= NEXT_LVL[level];
    end
  end

  scan_axis_counter #(
    .STEP (LANES * STRIDE)
  ) u_col_counter (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear),
    .advance (advance),
    .limit   (cur_max_col),
    .value   (col),
    .wrap    (col_wrap)
  );

  scan_axis_counter #(
    .STEP (STRIDE)
  ) u_row_counter (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear),
    .advance (advance && col_wrap),
    .limit   (cur_max_row),
    .value   (row),
    .wrap    (row_wrap)
  );

  // Payload is forced to zero whenever no beat is offered.
  assign win_level      = scan ? level : 4'd0;
  assign win_row        = scan ? COORD_W'(row) : '0;
  assign win_col        = scan ? COORD_W'(col) : '0;
  assign win_lane_mask  = scan ? LANES'(lane_mask_calc(col, cur_max_col, 32'(STRIDE), LANES)) : '0;
  assign win_level_last = scan && level_last;
  assign win_frame_last = scan && frame_last;

endmodule

`default_nettype wire

// File: tb/tb_scan_window_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_scan_window_sequencer                                        |
// | Purpose  : Self-checking bench for scan_window_sequencer over four         |
// |            configurations, driven from expected-beat tables.               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

module tb_scan_window_sequencer;

  localparam int S = 3;

  typedef struct {
    int level;
    int row;
    int col;
    int mask;
    int llast;
    int flast;
  } beat_t;

  logic clock = 1'b0;
  logic reset, abort, win_ready;
  logic [3:0] start_v;
  always #5 clock = ~clock;

  logic        v_valid [4];
  logic [3:0]  v_level [4];
  logic [15:0] v_row   [4];
  logic [15:0] v_col   [4];
  logic        v_llast [4];
  logic        v_flast [4];
  logic        v_busy  [4];
  logic        v_done  [4];
  logic [0:0]  mask_a, mask_b, mask_d;
  logic [1:0]  mask_c;

  // cfg 0: stride 1, one lane
  scan_window_sequencer #(.LEVELS(2), .LEVEL_WIDTHS({32'd6, 32'd8}), .LEVEL_HEIGHTS({32'd5, 32'd6}),
    .WINDOW_SIZE(4), .STRIDE(1), .LANES(1), .SETTLE_CYCLES(S), .COORD_W(16)) u_dut_a (
    .clock(clock), .reset(reset), .start(start_v[0]), .abort(abort), .win_valid(v_valid[0]),
    .win_ready(win_ready), .win_level(v_level[0]), .win_row(v_row[0]), .win_col(v_col[0]),
    .win_lane_mask(mask_a), .win_level_last(v_llast[0]), .win_frame_last(v_flast[0]),
    .busy(v_busy[0]), .done(v_done[0]));

  // cfg 1: stride 2, one lane
  scan_window_sequencer #(.LEVELS(2), .LEVEL_WIDTHS({32'd6, 32'd8}), .LEVEL_HEIGHTS({32'd5, 32'd6}),
    .WINDOW_SIZE(4), .STRIDE(2), .LANES(1), .SETTLE_CYCLES(S), .COORD_W(16)) u_dut_b (
    .clock(clock), .reset(reset), .start(start_v[1]), .abort(abort), .win_valid(v_valid[1]),
    .win_ready(win_ready), .win_level(v_level[1]), .win_row(v_row[1]), .win_col(v_col[1]),
    .win_lane_mask(mask_b), .win_level_last(v_llast[1]), .win_frame_last(v_flast[1]),
    .busy(v_busy[1]), .done(v_done[1]));

  // cfg 2: stride 1, two lanes, widths {7,6}
  scan_window_sequencer #(.LEVELS(2), .LEVEL_WIDTHS({32'd6, 32'd7}), .LEVEL_HEIGHTS({32'd5, 32'd6}),
    .WINDOW_SIZE(4), .STRIDE(1), .LANES(2), .SETTLE_CYCLES(S), .COORD_W(16)) u_dut_c (
    .clock(clock), .reset(reset), .start(start_v[2]), .abort(abort), .win_valid(v_valid[2]),
    .win_ready(win_ready), .win_level(v_level[2]), .win_row(v_row[2]), .win_col(v_col[2]),
    .win_lane_mask(mask_c), .win_level_last(v_llast[2]), .win_frame_last(v_flast[2]),
    .busy(v_busy[2]), .done(v_done[2]));

  // cfg 3: no level wider than the window
  scan_window_sequencer #(.LEVELS(2), .LEVEL_WIDTHS({32'd3, 32'd4}), .LEVEL_HEIGHTS({32'd5, 32'd6}),
    .WINDOW_SIZE(4), .STRIDE(1), .LANES(1), .SETTLE_CYCLES(S), .COORD_W(16)) u_dut_d (
    .clock(clock), .reset(reset), .start(start_v[3]), .abort(abort), .win_valid(v_valid[3]),
    .win_ready(win_ready), .win_level(v_level[3]), .win_row(v_row[3]), .win_col(v_col[3]),
    .win_lane_mask(mask_d), .win_level_last(v_llast[3]), .win_frame_last(v_flast[3]),
    .busy(v_busy[3]), .done(v_done[3]));

  int sel = 0;
  logic       m_valid, m_llast, m_flast, m_busy, m_done;
  logic [3:0] m_level;
  logic [15:0] m_row, m_col;
  logic [1:0] m_mask;

  always_comb begin
    m_valid = v_valid[sel];
    m_level = v_level[sel];
    m_row   = v_row[sel];
    m_col   = v_col[sel];
    m_llast = v_llast[sel];
    m_flast = v_flast[sel];
    m_busy  = v_busy[sel];
    m_done  = v_done[sel];
    case (sel)
      0:       m_mask = {1'b0, mask_a};
      1:       m_mask = {1'b0, mask_b};
      2:       m_mask = mask_c;
      default: m_mask = {1'b0, mask_d};
    endcase
  end

  int checks = 0;
  int errors = 0;
  beat_t tab [3][10];
  int    tab_n [3];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic rdy(input int mode, input int c);
    logic [3:0] pat;
    pat = 4'b1001;
    if (mode == 0) return 1'b1;
    return pat[(c - 1) % 4];
  endfunction

  task automatic chk_payload(input string tag, input beat_t e);
    chk({tag, "_level"}, int'(m_level), e.level);
    chk({tag, "_row"},   int'(m_row),   e.row);
    chk({tag, "_col"},   int'(m_col),   e.col);
    chk({tag, "_mask"},  int'(m_mask),  e.mask);
    chk({tag, "_llast"}, int'(m_llast), e.llast);
    chk({tag, "_flast"}, int'(m_flast), e.flast);
  endtask

  task automatic chk_idle_zero();
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_busy",  int'(m_busy),  0);
    chk("rst_done",  int'(m_done),  0);
    chk_payload("rst", '{0, 0, 0, 0, 0, 0});
  endtask

  // Start a frame on cfg and follow it beat by beat against the table.
  // stop_kind 1 = abort, 2 = reset, applied (stalled) when stop_beat is presented.
  task automatic run_scan(input int cfg, input int mode, input int stop_beat, input int stop_kind,
                          input int poke_start, input int exp_done_cyc);
    int cyc, beat, first;
    sel = cfg;
    @(posedge clock); #1 start_v[cfg] = 1'b1;
    @(posedge clock); #1 start_v[cfg] = 1'b0; win_ready = rdy(mode, 1);
    cyc = 1; beat = 0; first = -1;
    @(negedge clock);
    chk("busy_after_start", int'(m_busy), 1);
    while (beat < tab_n[cfg] && cyc < 200) begin
      if (m_valid) begin
        if (first < 0) begin
          first = cyc;
          chk("first_valid_cycle", cyc, 1 + S);
        end
        chk_payload("beat", tab[cfg][beat]);
        if (win_ready) beat++;
      end else if (first >= 0) begin
        chk("valid_dropped", 0, 1);
      end
      chk("done_early", int'(m_done), 0);
      if (stop_kind != 0 && first >= 0 && beat == stop_beat) begin
        @(posedge clock); #1 win_ready = 1'b0;
        if (stop_kind == 1) abort = 1'b1; else reset = 1'b1;
        @(negedge clock);
        chk("stall_valid", int'(m_valid), 1);
        chk("stall_row", int'(m_row), tab[cfg][stop_beat].row);
        chk("stall_col", int'(m_col), tab[cfg][stop_beat].col);
        @(posedge clock); #1 abort = 1'b0; reset = 1'b0; win_ready = 1'b1;
        @(negedge clock);
        if (stop_kind == 2) chk_idle_zero();
        else begin
          chk("abort_valid", int'(m_valid), 0);
          chk("abort_busy",  int'(m_busy),  0);
        end
        for (int k = 0; k < 3; k++) begin
          chk("no_done_after_stop", int'(m_done), 0);
          @(negedge clock);
        end
        return;
      end
      @(posedge clock); #1 win_ready = rdy(mode, cyc + 1);
      start_v[cfg] = (poke_start != 0) && (cyc + 1 == 2 || cyc + 1 == 7);
      @(negedge clock);
      cyc++;
    end
    start_v[cfg] = 1'b0;
    chk("beats_seen", beat, tab_n[cfg]);
    chk("done_pulse", int'(m_done), 1);
    chk("busy_at_done", int'(m_busy), 0);
    chk("valid_at_done", int'(m_valid), 0);
    if (exp_done_cyc > 0) chk("done_cycle", cyc, exp_done_cyc);
    win_ready = 1'b1;
    @(negedge clock);
    chk("done_one_cycle", int'(m_done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tab_n[0] = 10;
    tab[0][0] = '{0, 0, 0, 1, 0, 0};
    tab[0][1] = '{0, 0, 1, 1, 0, 0};
    tab[0][2] = '{0, 0, 2, 1, 0, 0};
    tab[0][3] = '{0, 0, 3, 1, 0, 0};
    tab[0][4] = '{0, 1, 0, 1, 0, 0};
    tab[0][5] = '{0, 1, 1, 1, 0, 0};
    tab[0][6] = '{0, 1, 2, 1, 0, 0};
    tab[0][7] = '{0, 1, 3, 1, 1, 0};
    tab[0][8] = '{1, 0, 0, 1, 0, 0};
    tab[0][9] = '{1, 0, 1, 1, 1, 1};
    tab_n[1] = 3;
    tab[1][0] = '{0, 0, 0, 1, 0, 0};
    tab[1][1] = '{0, 0, 2, 1, 1, 0};
    tab[1][2] = '{1, 0, 0, 1, 1, 1};
    tab_n[2] = 5;
    tab[2][0] = '{0, 0, 0, 3, 0, 0};
    tab[2][1] = '{0, 0, 2, 1, 0, 0};
    tab[2][2] = '{0, 1, 0, 3, 0, 0};
    tab[2][3] = '{0, 1, 2, 1, 1, 0};
    tab[2][4] = '{1, 0, 0, 3, 1, 1};

    reset = 1'b1; abort = 1'b0; win_ready = 1'b1; start_v = 4'd0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    sel = 0;
    chk_idle_zero();

    // Abort while idle is ignored.
    @(posedge clock); #1 abort = 1'b1;
    @(posedge clock); #1 abort = 1'b0;
    @(negedge clock);
    chk("idle_abort_busy", int'(m_busy), 0);

    run_scan(0, 0, -1, 0, 0, 14);   // constant ready
    run_scan(0, 1, -1, 0, 0, 0);    // ready 1,0,0,1 stalls
    run_scan(1, 0, -1, 0, 0, 7);    // stride 2
    run_scan(2, 0, -1, 0, 0, 9);    // two lanes
    run_scan(0, 1, 4, 1, 0, 0);     // abort on 5th beat
    run_scan(0, 0, -1, 0, 0, 14);   // fresh start after abort
    run_scan(0, 0, 5, 2, 0, 0);     // reset on 6th beat
    run_scan(0, 0, -1, 0, 1, 14);   // full frame, start pulsed while busy

    // No legal level: done arrives right after settling, with no beats.
    sel = 3;
    @(posedge clock); #1 start_v[3] = 1'b1;
    @(posedge clock); #1 start_v[3] = 1'b0;
    for (int k = 1; k <= S; k++) begin
      @(negedge clock);
      chk("illegal_settle_busy",  int'(m_busy),  1);
      chk("illegal_settle_valid", int'(m_valid), 0);
      chk("illegal_settle_done",  int'(m_done),  0);
    end
    @(negedge clock);
    chk("illegal_done",  int'(m_done),  1);
    chk("illegal_busy",  int'(m_busy),  0);
    chk("illegal_valid", int'(m_valid), 0);
    @(negedge clock);
    chk("illegal_done_one_cycle", int'(m_done), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/scan_window_sequencer.md
Name: scan_window_sequencer

Overview:
- Generalised scan-window address generator for the Viola-Jones detector.
- After the integral-image pyramid settles, walks every pyramid level in row-major order with a configurable stride. Emits LANES adjacent window positions per beat to the classifier pipeline over a valid/ready handshake.
- Replaces the fixed one-window-per-cycle, no-backpressure scan with stride, multi-lane, backpressure, abort and completion signalling.

Parameters:
- LEVELS, `PYRAMID_LEVELS, number of pyramid levels scanned.
- LEVEL_WIDTHS, `PYRAMID_WIDTHS, packed [LEVELS-1:0][31:0] width per level; index 0 is level 0.
- LEVEL_HEIGHTS, `PYRAMID_HEIGHTS, packed [LEVELS-1:0][31:0] height per level.
- WINDOW_SIZE, `WINDOW_SIZE, window edge in pixels.
- STRIDE, 1, step in pixels between window positions, rows and columns; must be ≥1.
- LANES, 1, window positions emitted per beat; must be ≥1.
- SETTLE_CYCLES, 10, wait after start before the first beat, for integral-image settling; must be ≥1.
- COORD_W, 16, width of row/column outputs.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse: new frame is loaded, begin scan.
- abort  in  1  cancel the scan in progress.
- win_valid  out  1  beat payload valid.
- win_ready  in  1  downstream accepts the beat.
- win_level  out  4  pyramid level of the beat.
- win_row  out  COORD_W  top row of all lanes.
- win_col  out  COORD_W  column of lane 0; lane i column = win_col + i*STRIDE.
- win_lane_mask  out  LANES  bit i set = lane i is a legal position.
- win_level_last  out  1  last beat of the current level.
- win_frame_last  out  1  last beat of the frame.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse: frame fully accepted.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, counters 0. Reset mid-scan discards the scan; no done pulse.
- Per-level limits: max_col = W-WINDOW_SIZE-1, max_row = H-WINDOW_SIZE-1.
  - Legal positions: multiples of STRIDE ≤ limit.
  - Levels with W or H ≤ WINDOW_SIZE are skipped, resolved at elaboration.
  - If no level is legal, start goes straight to a done pulse after SETTLE.
- State IDLE:
  - start sampled high at edge t → SETTLE; busy=1 from t+1.
  - abort in IDLE has no effect.
- State SETTLE:
  - Counter runs 1..SETTLE_CYCLES.
  - First win_valid is high in cycle t+1+SETTLE_CYCLES, at the first legal level, row 0, col 0.
- State SCAN:
  - A beat is accepted when win_valid && win_ready.
  - The payload must stay stable while win_valid && !win_ready.
  - win_valid stays high continuously until the final acceptance; no bubbles under constant ready.
  - On accept, col += LANES*STRIDE. If the new col > max_col: col=0, row += STRIDE. If the new row > max_row: move to the next legal level, row=col=0.
  - win_lane_mask bit i = (win_col + i*STRIDE ≤ max_col).
  - win_level_last = current row is the last legal row && the beat's last legal lane reaches the last legal col.
  - win_frame_last = win_level_last && level is the last legal level.
- Frame end: accepting the frame_last beat → IDLE next cycle, win_valid=0, busy=0, done=1 for exactly one cycle.
- Ignored inputs: start while busy is ignored.
- abort while busy (any state): next cycle IDLE, win_valid=0, busy=0, no done.
  - abort wins over a simultaneous acceptance; that beat counts as accepted downstream, but the sequencer does not advance.
- Arithmetic: internal counters are 32 bits, compared against elaboration-time limits; outputs are truncated to COORD_W. Parameters must keep coordinates < 2^COORD_W (elaboration assertion).

Decomposition:
- Package scan_seq_pkg holds:
  - the state enum (IDLE, SETTLE, SCAN);
  - constant functions level_max_col(), level_max_row(), level_legal() and first_legal_level()/next_legal_level() tables;
  - the lane-mask width type.
- One sub-module, scan_axis_counter: a stride/limit stepping counter with an advance input and a wrap output. It is instantiated twice: column (step LANES*STRIDE) and row (step STRIDE).

Test Plan:
Common config: LEVELS=2, WINDOW_SIZE=4, widths {8,6}, heights {6,5}, SETTLE_CYCLES=3, unless noted.
- STRIDE=1, LANES=1, win_ready=1, start at t:
  - level 0: 8 beats, (row,col) = (0,0)..(0,3),(1,0)..(1,3), level_last on (1,3);
  - level 1: 2 beats, (0,0),(0,1), frame_last on (0,1);
  - first valid at t+4, done at t+14.
- Same config, win_ready toggled 1,0,0,1 repeatedly → payload held stable during stalls; same 10 beats in order; done one cycle after the 10th acceptance.
- STRIDE=2, LANES=1 → level 0 beats (0,0),(0,2); level 1 beat (0,0); 3 beats total.
- LANES=2, STRIDE=1, widths {7,6} → level 0 per row: col 0 mask 11, col 2 mask 01; level 1: col 0 mask 11; level_last asserted on the correct masked beat.
- abort on the 5th beat while stalled → next cycle win_valid=0, busy=0, no done; a fresh start repeats the full sequence from level 0.
- reset at the 6th beat, then start; start pulsed while busy; config with all widths ≤ WINDOW_SIZE:
  - reset → all outputs 0; start after reset gives the full sequence;
  - start while busy is ignored;
  - all-illegal config → done at t+1+SETTLE with no beats.
